// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle accumulator CPU controller.
// The HOLD state is reached only when CTRL_SINGLE_STEP_EN is defined.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_ERR    = 3'd4,
    ST_HOLD   = 3'd5
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_ORA  = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  localparam logic ADDR_SEL_PC = 1'b0;
  localparam logic ADDR_SEL_IR = 1'b1;

endpackage

// File: rtl/ack_watchdog.sv
// Counts consecutive unacknowledged request cycles and pulses timeout when the
// count has reached ACK_TIMEOUT and the ack is still missing.
module ack_watchdog #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // The count saturates at LIMIT; the controller leaves the request state anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (!req || ack) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = req && !ack && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 8-bit accumulator CPU sharing one memory port.
// Define CTRL_SINGLE_STEP_EN to add the step input and the HOLD state.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       ir_op,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_addr_sel,
  output logic             ir_ld,
  output logic             pc_inc,
  output logic             pc_ld,
  output logic             ac_ld,
  output logic [2:0]       alu_op,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

`ifdef CTRL_SINGLE_STEP_EN
  localparam state_e RETIRE_ST = ST_HOLD;
`else
  localparam state_e RETIRE_ST = ST_FETCH;
`endif

  state_e state_q, state_d;
  logic   retire;
  logic   timeout;

  ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (mem_req),
    .ack    (mem_ack),
    .timeout(timeout)
  );

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_addr_sel = ADDR_SEL_PC;
    ir_ld        = 1'b0;
    pc_inc       = 1'b0;
    pc_ld        = 1'b0;
    ac_ld        = 1'b0;
    alu_op       = OP_ADD;
    retire       = 1'b0;
    unique case (state_q)
      ST_RST: begin
        state_d = RETIRE_ST;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: begin
        if (ir_op == OP_JMP) begin
          pc_ld   = 1'b1;
          retire  = 1'b1;
          state_d = RETIRE_ST;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        mem_req      = 1'b1;
        mem_addr_sel = ADDR_SEL_IR;
        alu_op       = ir_op;
        if (mem_ack) begin
          ac_ld   = 1'b1;
          retire  = 1'b1;
          state_d = RETIRE_ST;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
`ifdef CTRL_SINGLE_STEP_EN
      ST_HOLD: begin
        if (step) begin
          state_d = ST_FETCH;
        end
      end
`endif
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      instr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);
  assign err  = (state_q == ST_ERR);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: acts as the memory and instruction register, and checks
// each cycle against the instruction-level timing of the controller.
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int unsigned CW = 4;
  localparam int unsigned TO = 15;

  logic          clk;
  logic          rst_n;
  logic [2:0]    ir_op;
  logic          mem_ack;
  logic          mem_req;
  logic          mem_addr_sel;
  logic          ir_ld;
  logic          pc_inc;
  logic          pc_ld;
  logic          ac_ld;
  logic [2:0]    alu_op;
  logic          busy;
  logic          err;
  logic [CW-1:0] instr_cnt;
`ifdef CTRL_SINGLE_STEP_EN
  logic          step = 1'b1;
`endif

  logic [10:0] obs;
  logic [10:0] exp_v;
  int          total;
  int          bad;
  int          exp_cnt;

  multicycle_ctrl #(
    .ACK_TIMEOUT(TO),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ir_op       (ir_op),
`ifdef CTRL_SINGLE_STEP_EN
    .step        (step),
`endif
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_addr_sel(mem_addr_sel),
    .ir_ld       (ir_ld),
    .pc_inc      (pc_inc),
    .pc_ld       (pc_ld),
    .ac_ld       (ac_ld),
    .alu_op      (alu_op),
    .busy        (busy),
    .err         (err),
    .instr_cnt   (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {mem_req, mem_addr_sel, ir_ld, pc_inc, pc_ld, ac_ld, alu_op, busy, err};

  // One instruction: fetch with fw wait cycles, decode, then exec with ew waits.
  task automatic run_instr(input logic [2:0] op, input int fw, input int ew);
    logic a;
    for (int i = 0; i <= fw; i++) begin
      a = (i == fw);
      mem_ack = a;
      @(negedge clk);
      exp_v = {1'b1, ADDR_SEL_PC, a, a, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL fetch op=%0d cyc=%0d: got %b want %b", op, i, obs, exp_v);
      end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    ir_op   = op;
    @(negedge clk);
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, (op == OP_JMP), 1'b0, 3'b000, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL decode op=%0d: got %b want %b", op, obs, exp_v);
    end
    @(posedge clk);
    #1;
    if (op != OP_JMP) begin
      for (int i = 0; i <= ew; i++) begin
        a = (i == ew);
        mem_ack = a;
        @(negedge clk);
        exp_v = {1'b1, ADDR_SEL_IR, 1'b0, 1'b0, 1'b0, a, op, 1'b1, 1'b0};
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL exec op=%0d cyc=%0d: got %b want %b", op, i, obs, exp_v);
        end
        @(posedge clk);
        #1;
      end
      mem_ack = 1'b0;
    end
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    total++;
    if (instr_cnt !== CW'(exp_cnt)) begin
      bad++;
      $display("FAIL instr_cnt op=%0d: got %0d want %0d", op, instr_cnt, exp_cnt);
    end
  endtask

  // Reset for 3 cycles, release, ends #1 after the edge that enters FETCH.
  task automatic do_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== 11'b0 || instr_cnt !== '0) begin
        bad++;
        $display("FAIL reset cyc=%0d: got %b cnt=%0d want 0", i, obs, instr_cnt);
      end
      @(posedge clk);
      #1;
    end
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    exp_v = {1'b1, ADDR_SEL_PC, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL first_fetch: got %b want %b", obs, exp_v);
    end
    @(posedge clk);
    #1;
    run_instr(OP_SUB, 0, 0);
  endtask

  task automatic test_alu();
    run_instr(OP_SUB, 0, 0);
    run_instr(OP_NOT, 0, 0);
    run_instr(OP_XNOR, 1, 2);
  endtask

  task automatic test_jmp();
    run_instr(OP_JMP, 0, 0);
    run_instr(OP_JMP, 2, 0);
    run_instr(OP_ADD, 0, 0);
  endtask

  task automatic test_wait();
    run_instr(OP_AND, 0, 4);
    run_instr(OP_XOR, TO, TO);
    run_instr(OP_JMP, TO, 0);
  endtask

  task automatic test_timeout();
    mem_ack = 1'b0;
    for (int i = 0; i <= TO; i++) begin
      @(negedge clk);
      exp_v = {1'b1, ADDR_SEL_PC, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL timeout_wait cyc=%0d: got %b want %b", i, obs, exp_v);
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (obs !== 11'b000_0000_0001) begin
        bad++;
        $display("FAIL err_sticky cyc=%0d: got %b want 00000000001", i, obs);
      end
      @(posedge clk);
      #1;
    end
    do_reset();
    run_instr(OP_ORA, 0, 1);
  endtask

  task automatic test_reset_mid();
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    ir_op   = OP_SUB;
    @(posedge clk);
    #1;
    @(negedge clk);
    exp_v = {1'b1, ADDR_SEL_IR, 1'b0, 1'b0, 1'b0, 1'b0, OP_SUB, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL mid_exec: got %b want %b", obs, exp_v);
    end
    rst_n = 1'b0;
    #1;
    mem_ack = 1'b1;
    #1;
    total++;
    if (obs !== 11'b0 || instr_cnt !== '0) begin
      bad++;
      $display("FAIL mid_reset: got %b cnt=%0d want 0", obs, instr_cnt);
    end
    @(posedge clk);
    #1;
    do_reset();
    run_instr(OP_ADD, 0, 0);
    exp_cnt = 0;
    do_reset();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      run_instr(OP_JMP, int'($urandom_range(0, 2)), 0);
    end
    total++;
    if (instr_cnt !== 4'd1) begin
      bad++;
      $display("FAIL wrap: got %0d want 1", instr_cnt);
    end
  endtask

  task automatic test_random();
    int fw;
    int ew;
    for (int i = 0; i < 40; i++) begin
      fw = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, 3));
      ew = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, 3));
      run_instr(3'($urandom_range(0, 7)), fw, ew);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = 0;
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    ir_op   = 3'b000;
    test_reset();
    test_alu();
    test_jmp();
    test_wait();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the 8-bit accumulator CPU.
- Instruction fetch and data read share one single-port memory behind a req/ack handshake.
- Drives the pc, ir, acc and alu controls, counts retired instructions, and flags a memory-ack timeout.
- Sits between the datapath and the shared memory port; replaces the single-cycle combinational controller.

Parameters:
- ACK_TIMEOUT, 15: max consecutive cycles mem_req may wait without mem_ack before error (must be >= 1).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ir_op  in  3  opcode field from the instruction register (ir[7:5]).
- mem_ack  in  1  memory ack; read data valid in the same cycle.
- mem_req  out  1  memory request.
- mem_addr_sel  out  1  0 = pc drives the address, 1 = ir[4:0] drives the address.
- ir_ld  out  1  load ir from memory data.
- pc_inc  out  1  pc <= pc + 1 (5-bit wrap).
- pc_ld  out  1  pc <= ir[4:0].
- ac_ld  out  1  acc <= alu_out.
- alu_op  out  3  ALU operation.
- busy  out  1  high in any state except RST and ERR.
- err  out  1  sticky ack-timeout error.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- States: RST, FETCH, DECODE, EXEC, ERR; state register is 3 bits.
- rst_n low: state = RST, instr_cnt = 0, wait counter = 0, err = 0. All outputs 0 while in RST.
- Reset mid-operation aborts the instruction immediately; no partial loads occur.
- RST -> FETCH unconditionally on the first clk edge after rst_n is high.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0.
  - On mem_ack: ir_ld = 1 and pc_inc = 1 in that cycle, then -> DECODE.
- DECODE:
  - ir_op == 3'b111 (JMP): pc_ld = 1, instr_cnt += 1, then -> FETCH.
  - Otherwise -> EXEC.
- EXEC:
  - mem_req = 1, mem_addr_sel = 1, alu_op = ir_op.
  - On mem_ack: ac_ld = 1, instr_cnt += 1, then -> FETCH.
- alu_op is 3'b000 outside EXEC.
- Handshake:
  - mem_req is a Moore output: high for the whole FETCH/EXEC residency and low the cycle after ack.
  - ir_ld and ac_ld are Mealy outputs, gated by mem_ack.
  - The memory must hold data valid during the ack cycle.
- Latency with zero-wait ack: ALU instruction = 3 cycles (FETCH, DECODE, EXEC); JMP = 2 cycles. Each wait cycle adds 1.
- Exclusivity: pc_inc and pc_ld are never high together. ir_ld and ac_ld are never high together.
- Timeout:
  - The wait counter increments each cycle mem_req = 1 and mem_ack = 0, and clears on ack or state change.
  - If the counter equals ACK_TIMEOUT and mem_ack = 0: -> ERR, err = 1.
  - If mem_ack arrives in that same cycle, the ack wins and there is no error.
- ERR: all control outputs 0, err held high; exit only via rst_n.
- instr_cnt wraps from 2^CNT_W-1 to 0.
- Opcodes 000..110 all read memory. NOT (100) ignores the accumulator but still reads.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and state HOLD.
  - Every retire goes to HOLD instead of FETCH; RST also goes to HOLD.
  - HOLD -> FETCH in the cycle step == 1 is sampled.
  - busy = 0 in HOLD.
- Undefined: no step port, no HOLD state; behaviour exactly as above.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encodings ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_ERR, ST_HOLD;
  - opcode constants OP_ADD=000, OP_SUB, OP_AND, OP_ORA, OP_NOT, OP_XOR, OP_XNOR, OP_JMP=111;
  - ADDR_SEL_PC=0, ADDR_SEL_IR=1.
- One sub-module: ack_watchdog.
  - Parameterised by ACK_TIMEOUT.
  - Inputs: clk, rst_n, req, ack. Output: timeout pulse.

Test Plan:
- Reset with rst_n low for 3 cycles, then released: all outputs 0 in reset. First edge -> FETCH with mem_req = 1, mem_addr_sel = 0.
- Zero-wait ack, ir_op = 001: ir_ld + pc_inc at cycle 1; DECODE at cycle 2; EXEC cycle 3 with alu_op = 001, ac_ld = 1; instr_cnt = 1.
- ir_op = 111 with ack: pc_ld = 1 in DECODE, no EXEC, back to FETCH. pc_inc and pc_ld never coincide.
- mem_ack delayed 4 cycles in EXEC: mem_req held 5 cycles and ac_ld pulses exactly once. Then ack withheld for 16 cycles in FETCH (ACK_TIMEOUT = 15): err = 1, busy = 0, sticky until rst_n.
- Ack exactly at wait count 15: no err, normal progress. Separately, rst_n pulsed low mid-EXEC: state RST, no ac_ld, instr_cnt = 0.
- CNT_W = 4, 17 JMP instructions: instr_cnt wraps to 1. With CTRL_SINGLE_STEP_EN: stalls in HOLD until step = 1, exactly one instruction per step pulse.
